// File: rtl/vecmac_pkg.sv
// Shared constants, FSM encoding and result-entry layout for the vector-MAC
// accumulator stage.
package vecmac_pkg;

  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } vec_state_e;

  typedef struct packed {
    logic [DEF_ACC_W-1:0] sum;
    logic [DEF_CNT_W-1:0] count;
    logic                 ovf;
  } result_t;

  localparam int DEF_RES_W = $bits(result_t);

endpackage

// File: rtl/vecmac_result_fifo.sv
// Two-entry result FIFO with registered occupancy and full flag.
// Full is taken from the register, so a push is judged before any same-cycle pop.
module vecmac_result_fifo
  import vecmac_pkg::*;
#(
  parameter int DATA_W = DEF_RES_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_full
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              r_full;

  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_count_next;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && (r_count != 2'd0);

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (latch).
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: storage is reset too (only two words) so the head reads as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_next;
      r_full  <= (w_count_next == 2'd2);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_full  = r_full;

endmodule

// File: rtl/vecmac_accum.sv
// Accumulates the unsigned product stream into per-vector dot-product sums,
// delimited by in_last, and queues {sum, count, ovf} toward writeback.
module vecmac_accum
  import vecmac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam int RES_W = ACC_W + CNT_W + 1;

  vec_state_e       r_state;
  vec_state_e       w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_fifo_full;
  logic [RES_W-1:0] w_fifo_data;
  logic [RES_W-1:0] w_push_data;
  logic             w_accept;
  logic             w_take;
  logic             w_push;

  logic [ACC_W-1:0] w_acc_base;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_ovf_base;
  logic [ACC_W:0]   w_sum_ext;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ovf_next;

  assign in_ready = !w_fifo_full;
  assign w_accept = in_valid && in_ready;
  // A beat coinciding with clear is consumed by the handshake but contributes nothing.
  assign w_take   = w_accept && !clear;
  assign w_push   = w_take && in_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_take && !in_last)              w_state_next = ST_ACC;
      ST_ACC:  if (clear || (w_take && in_last))    w_state_next = ST_IDLE;
      default:                                      w_state_next = ST_IDLE;
    endcase
  end

  // The first beat of a vector always starts from a clean base.
  always_comb begin
    w_acc_base = '0;
    w_cnt_base = '0;
    w_ovf_base = 1'b0;
    if (r_state == ST_ACC) begin
      w_acc_base = r_acc;
      w_cnt_base = r_cnt;
      w_ovf_base = r_ovf;
    end
  end

  assign w_sum_ext  = {1'b0, w_acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
  assign w_cnt_sat  = &w_cnt_base;
  assign w_cnt_next = w_cnt_sat ? w_cnt_base : w_cnt_base + CNT_W'(1);
  assign w_ovf_next = w_ovf_base | w_sum_ext[ACC_W] | w_cnt_sat;

  assign w_push_data = {w_sum_ext[ACC_W-1:0], w_cnt_next, w_ovf_next};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clear || w_push) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_take) begin
      r_acc <= w_sum_ext[ACC_W-1:0];
      r_cnt <= w_cnt_next;
      r_ovf <= w_ovf_next;
    end
  end

  vecmac_result_fifo #(
    .DATA_W (RES_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (out_ready),
    .o_data  (w_fifo_data),
    .o_valid (out_valid),
    .o_full  (w_fifo_full)
  );

  assign out_sum   = w_fifo_data[RES_W-1 -: ACC_W];
  assign out_count = w_fifo_data[CNT_W:1];
  assign out_ovf   = w_fifo_data[0];

endmodule

// File: tb/tb_vecmac_accum.sv
// Drives one stimulus stream into a default-width instance and a narrow
// (16-bit sum, 4-bit count) instance and checks both against a vector-level model.
module tb_vecmac_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_product = '0;
  logic        in_last = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [31:0] a_out_sum;
  logic [15:0] a_out_count;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [15:0] b_out_sum;
  logic [3:0]  b_out_count;

  always #5 clk = ~clk;

  vecmac_accum u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (a_in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .clear      (clear),
    .out_valid  (a_out_valid),
    .out_ready  (out_ready),
    .out_sum    (a_out_sum),
    .out_count  (a_out_count),
    .out_ovf    (a_out_ovf)
  );

  vecmac_accum #(
    .PROD_W (16),
    .ACC_W  (16),
    .CNT_W  (4)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (b_in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .clear      (clear),
    .out_valid  (b_out_valid),
    .out_ready  (out_ready),
    .out_sum    (b_out_sum),
    .out_count  (b_out_count),
    .out_ovf    (b_out_ovf)
  );

  // A finished vector is just its exact total and its element count.
  typedef struct {
    longint total;
    int     n;
  } vec_t;

  vec_t   q[$];
  longint cur_total = 0;
  int     cur_n = 0;
  int     n_compared = 0;
  int     n_mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_dut(input string who, input int aw, input int cw,
                           input logic ir, input logic ov,
                           input logic [63:0] s, input logic [63:0] c, input logic o);
    longint amod = longint'(1) << aw;
    longint cmax = (longint'(1) << cw) - 1;
    check({who, " in_ready"}, 64'(ir), 64'(q.size() < 2));
    check({who, " out_valid"}, 64'(ov), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check({who, " out_sum"}, s, 64'(q[0].total % amod));
      check({who, " out_count"}, c, 64'((longint'(q[0].n) > cmax) ? cmax : longint'(q[0].n)));
      check({who, " out_ovf"}, 64'(o), 64'((q[0].total >= amod) || (longint'(q[0].n) > cmax)));
    end
  endtask

  task automatic step(input logic v, input logic [15:0] p, input logic l,
                      input logic clr, input logic ordy, output logic accepted);
    @(negedge clk);
    check_dut("A", 32, 16, a_in_ready, a_out_valid, 64'(a_out_sum), 64'(a_out_count), a_out_ovf);
    check_dut("B", 16, 4, b_in_ready, b_out_valid, 64'(b_out_sum), 64'(b_out_count), b_out_ovf);
    in_valid   = v;
    in_product = p;
    in_last    = l;
    clear      = clr;
    out_ready  = ordy;
    accepted = v && (q.size() < 2);
    if (ordy && q.size() > 0) void'(q.pop_front());
    if (clr) begin
      cur_total = 0;
      cur_n     = 0;
    end else if (accepted) begin
      cur_total += longint'(p);
      cur_n++;
      if (l) begin
        q.push_back('{cur_total, cur_n});
        cur_total = 0;
        cur_n     = 0;
      end
    end
  endtask

  task automatic send(input logic [15:0] p, input logic l, input logic ordy);
    logic acc;
    int   tries = 0;
    do begin
      step(1'b1, p, l, 1'b0, ordy, acc);
      tries++;
    end while (!acc && tries < 32);
    if (!acc) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL send_budget: beat %0d never accepted in %0d cycles", p, tries);
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    repeat (n) step(1'b0, 16'd0, 1'b0, 1'b0, ordy, acc);
  endtask

  task automatic check_reset_state();
    check("A rst in_ready", 64'(a_in_ready), 64'd1);
    check("A rst out_valid", 64'(a_out_valid), 64'd0);
    check("A rst out_sum", 64'(a_out_sum), 64'd0);
    check("A rst out_count", 64'(a_out_count), 64'd0);
    check("A rst out_ovf", 64'(a_out_ovf), 64'd0);
    check("B rst in_ready", 64'(b_in_ready), 64'd1);
    check("B rst out_valid", 64'(b_out_valid), 64'd0);
    check("B rst out_sum", 64'(b_out_sum), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, pending, hv, hl, clr, ordy;
    logic [15:0] hp;

    #3 check_reset_state();
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // Full-scale products, result visible one edge after the last accept.
    repeat (3) send(16'd65025, 1'b0, 1'b0);
    send(16'd65025, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Zero and single-element vectors back to back.
    send(16'd0, 1'b1, 1'b1);
    send(16'd256, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Backpressure: third single-element vector is held until a pop.
    send(16'd1, 1'b1, 1'b0);
    send(16'd2, 1'b1, 1'b0);
    repeat (3) step(1'b1, 16'd3, 1'b1, 1'b0, 1'b0, acc);
    send(16'd3, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Sum wrap on the narrow instance, then a clean vector.
    send(16'd65025, 1'b0, 1'b1);
    send(16'd65025, 1'b1, 1'b1);
    send(16'd5, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Clear mid-vector, clear with a last beat, clear with a single-element last beat.
    send(16'd10, 1'b0, 1'b1);
    send(16'd20, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, acc);
    send(16'd5, 1'b1, 1'b1);
    idle(2, 1'b1);
    send(16'd7, 1'b0, 1'b1);
    step(1'b1, 16'd9, 1'b1, 1'b1, 1'b1, acc);
    step(1'b1, 16'd4, 1'b1, 1'b1, 1'b1, acc);
    idle(3, 1'b1);

    // Count saturation on the 4-bit counter: 15 elements, then 16.
    repeat (14) send(16'd1, 1'b0, 1'b1);
    send(16'd1, 1'b1, 1'b1);
    repeat (15) send(16'd2, 1'b0, 1'b1);
    send(16'd2, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Asynchronous reset with results pending and a partial vector.
    send(16'd11, 1'b1, 1'b0);
    send(16'd12, 1'b1, 1'b0);
    idle(1, 1'b1);
    send(16'd30, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_state();
    q.delete();
    cur_total = 0;
    cur_n     = 0;
    @(negedge clk);
    #1 rst = 1'b0;
    send(16'd7, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic, holding a stalled beat stable until it is taken.
    pending = 1'b0;
    hv = 1'b0;
    hl = 1'b0;
    hp = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pending) begin
        hv = ($urandom_range(0, 3) != 0);
        hp = 16'($urandom_range(0, 65535));
        hl = ($urandom_range(0, 3) == 0);
      end
      clr  = ($urandom_range(0, 15) == 0);
      ordy = ($urandom_range(0, 1) == 1);
      step(hv, hp, hl, clr, ordy, acc);
      pending = hv && !acc;
    end
    idle(4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
